// File: rtl/lsu_pkg.sv
// Load/store unit shared types.
// State encoding, op encoding and alignment helper.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } lsu_state_t;

  localparam logic LSU_OP_LOAD  = 1'b0;
  localparam logic LSU_OP_STORE = 1'b1;

  function automatic logic misaligned(
    input logic [1:0] lo
  );
    return lo != 2'b00;
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Request handshake between control path and LSU.
// Master drives the request, slave returns ready.
interface load_store_unit_if #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int REG_SEL_W = 4
) ();

  logic                 req_valid;
  logic                 req_ready;
  logic                 req_is_store;
  logic [ADDR_W-1:0]    req_addr;
  logic [DATA_W-1:0]    req_wdata;
  logic [REG_SEL_W-1:0] req_rd;

  modport master (
    output req_valid,
    output req_is_store,
    output req_addr,
    output req_wdata,
    output req_rd,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_is_store,
    input  req_addr,
    input  req_wdata,
    input  req_rd,
    output req_ready
  );

endinterface

// File: rtl/load_store_unit.sv
// RAM ldr/str initiator: one request at a time,
// waits RAM read latency, writes load data back.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int REG_SEL_W   = 4,
  parameter int RAM_RD_LAT  = 1,
  parameter int ALIGN_CHECK = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  load_store_unit_if.slave     req,
  output logic                 ram_ldr,
  output logic                 ram_str,
  output logic [ADDR_W-1:0]    ram_address,
  output logic [DATA_W-1:0]    ram_mem_in,
  input  logic [DATA_W-1:0]    ram_mem_out,
  output logic                 wb_en,
  output logic [REG_SEL_W-1:0] wb_sel,
  output logic [DATA_W-1:0]    wb_data,
  output logic                 done,
  output logic                 err
);

  localparam int CNT_W = $clog2(RAM_RD_LAT) + 1;

  lsu_state_t           state;
  logic                 rdy_q;
  logic                 op_q;
  logic [REG_SEL_W-1:0] rd_q;
  logic [CNT_W-1:0]     cnt;
  logic                 bad;

  assign req.req_ready = rdy_q;
  assign bad = (ALIGN_CHECK != 0) &&
               misaligned(req.req_addr[1:0]);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      rdy_q       <= 1'b1;
      op_q        <= LSU_OP_LOAD;
      rd_q        <= '0;
      cnt         <= '0;
      ram_ldr     <= 1'b0;
      ram_str     <= 1'b0;
      ram_address <= '0;
      ram_mem_in  <= '0;
      wb_en       <= 1'b0;
      wb_sel      <= '0;
      wb_data     <= '0;
      done        <= 1'b0;
      err         <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req.req_valid) begin
            op_q  <= req.req_is_store;
            rd_q  <= req.req_rd;
            rdy_q <= 1'b0;
            // misaligned requests never touch RAM
            if (bad) begin
              state <= RESP;
              done  <= 1'b1;
              err   <= 1'b1;
            end else begin
              state       <= ISSUE;
              ram_address <= req.req_addr;
              ram_mem_in  <= req.req_wdata;
              ram_str     <= req.req_is_store == LSU_OP_STORE;
              ram_ldr     <= req.req_is_store == LSU_OP_LOAD;
            end
          end
        end
        ISSUE: begin
          ram_ldr <= 1'b0;
          ram_str <= 1'b0;
          if (op_q == LSU_OP_STORE) begin
            state <= RESP;
            done  <= 1'b1;
          end else begin
            state <= WAIT;
            cnt   <= CNT_W'(RAM_RD_LAT - 1);
          end
        end
        WAIT: begin
          if (cnt == '0) begin
            state   <= RESP;
            wb_data <= ram_mem_out;
            wb_sel  <= rd_q;
            wb_en   <= 1'b1;
            done    <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP: begin
          state <= IDLE;
          rdy_q <= 1'b1;
          wb_en <= 1'b0;
          done  <= 1'b0;
          err   <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed and scoreboard bench for load_store_unit.
// Two instances: RAM read latency 3 and 1.
module tb_load_store_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int both_hi  = 0;

  // latency-3 instance
  load_store_unit_if #(32, 32, 4) rq3 ();
  logic        ldr3, str3, wen3, done3, err3;
  logic [31:0] addr3, min3, mout3, wdat3;
  logic [3:0]  wsel3;
  logic [31:0] ram3 [64];
  logic [2:0]  age3 = 3'd0;

  load_store_unit #(
    .RAM_RD_LAT(3)
  ) u_dut3 (
    .clk(clk), .rst(rst), .req(rq3),
    .ram_ldr(ldr3), .ram_str(str3),
    .ram_address(addr3), .ram_mem_in(min3),
    .ram_mem_out(mout3),
    .wb_en(wen3), .wb_sel(wsel3), .wb_data(wdat3),
    .done(done3), .err(err3)
  );

  // latency-1 instance
  load_store_unit_if #(32, 32, 4) rq1 ();
  logic        ldr1, str1, wen1, done1, err1;
  logic [31:0] addr1, min1, mout1, wdat1;
  logic [3:0]  wsel1;
  logic [31:0] ram1 [64];
  logic [2:0]  age1 = 3'd0;

  load_store_unit #(
    .RAM_RD_LAT(1)
  ) u_dut1 (
    .clk(clk), .rst(rst), .req(rq1),
    .ram_ldr(ldr1), .ram_str(str1),
    .ram_address(addr1), .ram_mem_in(min1),
    .ram_mem_out(mout1),
    .wb_en(wen1), .wb_sel(wsel1), .wb_data(wdat1),
    .done(done1), .err(err1)
  );

  // RAM models: data valid only in the cycle LAT after ldr
  always @(posedge clk) begin
    if (str3) ram3[addr3[7:2]] <= min3;
    if (ldr3) age3 <= 3'd1;
    else if (age3 != 3'd0 && age3 != 3'd7)
      age3 <= age3 + 3'd1;
    if (str1) ram1[addr1[7:2]] <= min1;
    if (ldr1) age1 <= 3'd1;
    else if (age1 != 3'd0 && age1 != 3'd7)
      age1 <= age1 + 3'd1;
  end
  assign mout3 = (age3 == 3'd3) ?
    ram3[addr3[7:2]] : 32'hBAD0_BAD0;
  assign mout1 = (age1 == 3'd1) ?
    ram1[addr1[7:2]] : 32'hBAD0_BAD0;

  always @(negedge clk)
    if (ldr3 && str3) both_hi <= both_hi + 1;

  logic [31:0] exp_mem [64];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive3(input logic st,
                        input logic [31:0] a,
                        input logic [31:0] d,
                        input logic [3:0] rd);
    rq3.req_valid    = 1'b1;
    rq3.req_is_store = st;
    rq3.req_addr     = a;
    rq3.req_wdata    = d;
    rq3.req_rd       = rd;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    n_checks++;
    if (rq3.req_ready !== 1'b1 || ldr3 !== 1'b0 ||
        str3 !== 1'b0 || done3 !== 1'b0 ||
        err3 !== 1'b0 || wen3 !== 1'b0)
      $display("FAIL reset_ctl got rdy=%b ldr=%b str=%b dn=%b er=%b we=%b want 1 0 0 0 0 0",
               rq3.req_ready, ldr3, str3, done3, err3, wen3);
    else n_pass++;
    n_checks++;
    if (addr3 !== 32'h0 || min3 !== 32'h0 ||
        wdat3 !== 32'h0 || wsel3 !== 4'h0)
      $display("FAIL reset_data got a=%h mi=%h wd=%h ws=%h want 0",
               addr3, min3, wdat3, wsel3);
    else n_pass++;
    rst = 1'b0;
    tick();
    n_checks++;
    if (rq3.req_ready !== 1'b1 || rq1.req_ready !== 1'b1)
      $display("FAIL reset_idle got %b %b want 1 1",
               rq3.req_ready, rq1.req_ready);
    else n_pass++;
  endtask

  task automatic test_reset_mid_load();
    logic seen;
    drive3(1'b0, 32'h10, 32'h0, 4'd7);
    tick();
    rq3.req_valid = 1'b0;
    n_checks++;
    if (ldr3 !== 1'b1)
      $display("FAIL rml_ldr got %b want 1", ldr3);
    else n_pass++;
    tick();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    n_checks++;
    if (rq3.req_ready !== 1'b1 || wen3 !== 1'b0 ||
        done3 !== 1'b0)
      $display("FAIL rml_state got rdy=%b we=%b dn=%b want 1 0 0",
               rq3.req_ready, wen3, done3);
    else n_pass++;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      seen |= done3 | wen3 | ldr3 | str3;
    end
    n_checks++;
    if (seen !== 1'b0 || rq3.req_ready !== 1'b1)
      $display("FAIL rml_quiet got act=%b rdy=%b want 0 1",
               seen, rq3.req_ready);
    else n_pass++;
  endtask

  task automatic test_store();
    drive3(1'b1, 32'h10, 32'hDEADBEEF, 4'd0);
    tick();
    rq3.req_valid = 1'b0;
    n_checks++;
    if (str3 !== 1'b1 || ldr3 !== 1'b0 ||
        addr3 !== 32'h10 || min3 !== 32'hDEADBEEF ||
        done3 !== 1'b0 || rq3.req_ready !== 1'b0)
      $display("FAIL st_c1 got str=%b ldr=%b a=%h d=%h dn=%b rdy=%b want 1 0 10 deadbeef 0 0",
               str3, ldr3, addr3, min3, done3, rq3.req_ready);
    else n_pass++;
    tick();
    n_checks++;
    if (done3 !== 1'b1 || err3 !== 1'b0 ||
        str3 !== 1'b0 || wen3 !== 1'b0 ||
        addr3 !== 32'h10)
      $display("FAIL st_c2 got dn=%b er=%b str=%b we=%b a=%h want 1 0 0 0 10",
               done3, err3, str3, wen3, addr3);
    else n_pass++;
    tick();
    n_checks++;
    if (done3 !== 1'b0 || rq3.req_ready !== 1'b1)
      $display("FAIL st_c3 got dn=%b rdy=%b want 0 1",
               done3, rq3.req_ready);
    else n_pass++;
  endtask

  task automatic test_load_lat3();
    logic early;
    drive3(1'b0, 32'h10, 32'h0, 4'd5);
    tick();
    rq3.req_valid = 1'b0;
    n_checks++;
    if (ldr3 !== 1'b1 || str3 !== 1'b0 ||
        addr3 !== 32'h10)
      $display("FAIL ld3_c1 got ldr=%b str=%b a=%h want 1 0 10",
               ldr3, str3, addr3);
    else n_pass++;
    early = 1'b0;
    for (int c = 2; c <= 4; c++) begin
      tick();
      early |= done3 | wen3 | ldr3;
    end
    n_checks++;
    if (early !== 1'b0)
      $display("FAIL ld3_wait got early=%b want 0", early);
    else n_pass++;
    tick();
    n_checks++;
    if (wen3 !== 1'b1 || wsel3 !== 4'd5 ||
        wdat3 !== 32'hDEADBEEF || done3 !== 1'b1 ||
        err3 !== 1'b0)
      $display("FAIL ld3_c5 got we=%b ws=%0d wd=%h dn=%b er=%b want 1 5 deadbeef 1 0",
               wen3, wsel3, wdat3, done3, err3);
    else n_pass++;
    tick();
    n_checks++;
    if (wen3 !== 1'b0 || wdat3 !== 32'hDEADBEEF ||
        wsel3 !== 4'd5 || rq3.req_ready !== 1'b1)
      $display("FAIL ld3_c6 got we=%b wd=%h ws=%0d rdy=%b want 0 deadbeef 5 1",
               wen3, wdat3, wsel3, rq3.req_ready);
    else n_pass++;
  endtask

  task automatic test_load_lat1();
    rq1.req_valid    = 1'b1;
    rq1.req_is_store = 1'b1;
    rq1.req_addr     = 32'h10;
    rq1.req_wdata    = 32'hDEADBEEF;
    rq1.req_rd       = 4'd0;
    tick();
    rq1.req_valid = 1'b0;
    tick();
    tick();
    rq1.req_valid    = 1'b1;
    rq1.req_is_store = 1'b0;
    rq1.req_wdata    = 32'h0;
    rq1.req_rd       = 4'd5;
    tick();
    rq1.req_valid = 1'b0;
    n_checks++;
    if (ldr1 !== 1'b1 || str1 !== 1'b0)
      $display("FAIL ld1_c1 got ldr=%b str=%b want 1 0",
               ldr1, str1);
    else n_pass++;
    tick();
    n_checks++;
    if (wen1 !== 1'b0 || done1 !== 1'b0)
      $display("FAIL ld1_c2 got we=%b dn=%b want 0 0",
               wen1, done1);
    else n_pass++;
    tick();
    n_checks++;
    if (wen1 !== 1'b1 || wsel1 !== 4'd5 ||
        wdat1 !== 32'hDEADBEEF || done1 !== 1'b1)
      $display("FAIL ld1_c3 got we=%b ws=%0d wd=%h dn=%b want 1 5 deadbeef 1",
               wen1, wsel1, wdat1, done1);
    else n_pass++;
    tick();
    n_checks++;
    if (rq1.req_ready !== 1'b1 || wen1 !== 1'b0)
      $display("FAIL ld1_c4 got rdy=%b we=%b want 1 0",
               rq1.req_ready, wen1);
    else n_pass++;
  endtask

  task automatic test_misaligned();
    logic strobe;
    strobe = 1'b0;
    drive3(1'b0, 32'h13, 32'h0, 4'd2);
    tick();
    rq3.req_valid = 1'b0;
    strobe |= ldr3 | str3;
    n_checks++;
    if (done3 !== 1'b1 || err3 !== 1'b1 ||
        wen3 !== 1'b0)
      $display("FAIL mis_ld got dn=%b er=%b we=%b want 1 1 0",
               done3, err3, wen3);
    else n_pass++;
    tick();
    strobe |= ldr3 | str3;
    n_checks++;
    if (done3 !== 1'b0 || err3 !== 1'b0 ||
        rq3.req_ready !== 1'b1)
      $display("FAIL mis_end got dn=%b er=%b rdy=%b want 0 0 1",
               done3, err3, rq3.req_ready);
    else n_pass++;
    drive3(1'b1, 32'h22, 32'h5555AAAA, 4'd0);
    tick();
    rq3.req_valid = 1'b0;
    strobe |= ldr3 | str3;
    n_checks++;
    if (done3 !== 1'b1 || err3 !== 1'b1)
      $display("FAIL mis_st got dn=%b er=%b want 1 1",
               done3, err3);
    else n_pass++;
    tick();
    strobe |= ldr3 | str3;
    n_checks++;
    if (strobe !== 1'b0)
      $display("FAIL mis_strobe got %b want 0", strobe);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int first_done;
    int acc2;
    int ld_done;
    first_done = -1;
    acc2 = -1;
    ld_done = -1;
    drive3(1'b1, 32'h20, 32'h12345678, 4'd0);
    tick();
    drive3(1'b0, 32'h20, 32'h0, 4'd3);
    for (int c = 1; c < 20 && ld_done < 0; c++) begin
      if (done3 && first_done < 0) first_done = c;
      else if (done3 && acc2 >= 0) begin
        ld_done = c;
        n_checks++;
        if (wen3 !== 1'b1 || wsel3 !== 4'd3 ||
            wdat3 !== 32'h12345678)
          $display("FAIL b2b_data got we=%b ws=%0d wd=%h want 1 3 12345678",
                   wen3, wsel3, wdat3);
        else n_pass++;
      end
      if (rq3.req_valid && rq3.req_ready && acc2 < 0) begin
        acc2 = c;
        tick();
        rq3.req_valid = 1'b0;
      end else begin
        tick();
      end
    end
    n_checks++;
    if (first_done != 2 || acc2 != first_done + 1)
      $display("FAIL b2b_accept got done=%0d acc=%0d want 2 3",
               first_done, acc2);
    else n_pass++;
    n_checks++;
    if (ld_done != acc2 + 5)
      $display("FAIL b2b_ld_lat got %0d want %0d",
               ld_done, acc2 + 5);
    else n_pass++;
    n_checks++;
    if (both_hi != 0)
      $display("FAIL b2b_both got %0d want 0", both_hi);
    else n_pass++;
    rq3.req_valid = 1'b0;
    tick();
  endtask

  task automatic do_op(input  logic st,
                       input  logic [31:0] a,
                       input  logic [31:0] d,
                       input  logic [3:0] rd,
                       output logic ok,
                       output logic we,
                       output logic [31:0] rdata,
                       output logic [3:0] rsel,
                       output logic rerr);
    int n;
    n = 0;
    while (!rq3.req_ready && n < 20) begin
      tick();
      n++;
    end
    drive3(st, a, d, rd);
    tick();
    rq3.req_valid = 1'b0;
    n = 0;
    while (!done3 && n < 20) begin
      tick();
      n++;
    end
    ok    = done3;
    we    = wen3;
    rdata = wdat3;
    rsel  = wsel3;
    rerr  = err3;
  endtask

  task automatic test_random();
    logic        ok, we, re, st;
    logic [31:0] rdat, d;
    logic [3:0]  rs, rd;
    int          w;
    for (int i = 0; i < 64; i++) begin
      d = $urandom;
      exp_mem[i] = d;
      do_op(1'b1, 32'(i * 4), d, 4'd0,
            ok, we, rdat, rs, re);
      n_checks++;
      if (!ok || we || re)
        $display("FAIL rnd_fill got ok=%b we=%b er=%b want 1 0 0",
                 ok, we, re);
      else n_pass++;
    end
    for (int i = 0; i < 1000; i++) begin
      st = 1'($urandom_range(0, 1));
      w  = $urandom_range(0, 63);
      d  = $urandom;
      rd = 4'($urandom_range(0, 15));
      do_op(st, 32'(w * 4), d, rd, ok, we, rdat, rs, re);
      n_checks++;
      if (st) begin
        exp_mem[w] = d;
        if (!ok || we || re)
          $display("FAIL rnd_st got ok=%b we=%b er=%b want 1 0 0",
                   ok, we, re);
        else n_pass++;
      end else begin
        if (!ok || !we || re || rs !== rd ||
            rdat !== exp_mem[w])
          $display("FAIL rnd_ld got ok=%b we=%b ws=%0d wd=%h want 1 1 %0d %h",
                   ok, we, rs, rdat, rd, exp_mem[w]);
        else n_pass++;
      end
    end
  endtask

  initial begin
    rq3.req_valid    = 1'b0;
    rq3.req_is_store = 1'b0;
    rq3.req_addr     = '0;
    rq3.req_wdata    = '0;
    rq3.req_rd       = '0;
    rq1.req_valid    = 1'b0;
    rq1.req_is_store = 1'b0;
    rq1.req_addr     = '0;
    rq1.req_wdata    = '0;
    rq1.req_rd       = '0;
    test_reset();
    test_reset_mid_load();
    test_store();
    test_load_lat3();
    test_load_lat1();
    test_misaligned();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
